// File: rtl/mms_stream_acc.sv
// mms_stream_acc: per-frame streaming max/min of N unsigned numbers with ready/valid handshakes.
// Define MMS_INDEX_EN to add result_idx, the earliest position of the winning element.
module mms_stream_acc #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          select,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result
`ifdef MMS_INDEX_EN
    ,
    output logic [7:0]    result_idx
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state, state_nxt;
    logic [7:0] count;
    logic [DW-1:0] acc;
    logic mode;
    logic xfer, win, last;
    assign xfer = in_valid && in_ready;
    // strict compare: ties keep the earlier element
    assign win = mode ? (in_data < acc) : (in_data > acc);
    assign last = count == 8'(N - 1);
    assign result = acc;
    always_comb begin
        in_ready = state != HOLD;
        out_valid = state == HOLD;
        state_nxt = (state == IDLE && xfer) ? ACCUM :
                    (state == ACCUM && xfer && last) ? HOLD :
                    (state == HOLD && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            acc <= '0;
            mode <= 1'b0;
        end else if (xfer && state == IDLE) begin
            mode <= select;
            acc <= in_data;
            count <= 8'd1;
        end else if (xfer) begin
            count <= count + 8'd1;
            if (win) acc <= in_data;
        end else if (out_valid && out_ready) begin
            count <= '0;
        end
    end
`ifdef MMS_INDEX_EN
    logic [7:0] idx;
    assign result_idx = idx;
    always_ff @(posedge clk) begin
        if (reset) idx <= '0;
        else if (xfer && state == IDLE) idx <= '0;
        else if (xfer && win) idx <= count;
    end
`endif
endmodule

// File: tb/tb_mms_stream_acc.sv
// tb_mms_stream_acc: directed frame table plus corner sequences and a random-gap model check.
module tb_mms_stream_acc;
    logic clk = 1'b0;
    logic reset, select, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, result;
    logic [7:0] result_idx_w;
    int n_cmp = 0;
    int n_bad = 0;

    mms_stream_acc #(.DW(8), .N(8)) dut (
        .clk(clk), .reset(reset), .select(select), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
`ifdef MMS_INDEX_EN
        , .result_idx(result_idx_w)
`endif
    );
`ifndef MMS_INDEX_EN
    assign result_idx_w = '0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic sel;
        logic tog;
        logic [0:7][7:0] d;
        logic [7:0] res;
        logic [7:0] idx;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input int maxgap);
        int g;
        for (int i = 0; i < 8; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                if (v.tog) select = ~select;
                step();
            end
            in_valid = 1'b1;
            in_data = v.d[i];
            select = (i == 0) ? v.sel : (v.tog ? ~select : select);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string nm, input vec_t v);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_ready_low"}, 32'(in_ready), 32'd0);
        chk({nm, "_result"}, 32'(result), 32'(v.res));
`ifdef MMS_INDEX_EN
        chk({nm, "_idx"}, 32'(result_idx_w), 32'(v.idx));
`endif
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        step();
        chk({nm, "_valid_clr"}, 32'(out_valid), 32'd0);
        chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [7:0] r, ix;
        int pulses;
        vecs[0] = '{1'b0, 1'b0, {8'd3, 8'd9, 8'd1, 8'd9, 8'd7, 8'd0, 8'd2, 8'd5}, 8'd9, 8'd1};
        vecs[1] = '{1'b1, 1'b1, {8'd200, 8'd17, 8'd17, 8'd255, 8'd40, 8'd18, 8'd99, 8'd17}, 8'd17, 8'd1};
        vecs[2] = '{1'b0, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8'd8, 8'd7};
        vecs[3] = '{1'b1, 1'b0, {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5}, 8'd5, 8'd0};
        vecs[4] = '{1'b0, 1'b1, {8'd255, 8'd0, 8'd255, 8'd1, 8'd254, 8'd255, 8'd2, 8'd3}, 8'd255, 8'd0};
        vecs[5] = '{1'b1, 1'b0, {8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248}, 8'd248, 8'd7};
        vecs[6] = '{1'b0, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd0, 8'd0};
        vecs[7] = '{1'b1, 1'b1, {8'd10, 8'd3, 8'd7, 8'd0, 8'd0, 8'd9, 8'd1, 8'd2}, 8'd0, 8'd3};

        reset = 1'b1; select = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
`ifdef MMS_INDEX_EN
        chk("rst_idx", 32'(result_idx_w), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // out_ready held high while idle/accumulating must be ignored
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(vecs[k], 0);
            check_out($sformatf("vec%0d", k), vecs[k]);
            handshake($sformatf("vec%0d", k));
            out_ready = 1'b1;
        end
        out_ready = 1'b0;

        send(vecs[0], 0);
        for (int c = 0; c < 5; c++) begin
            check_out($sformatf("hold%0d", c), vecs[0]);
            step();
        end
        check_out("hold_end", vecs[0]);
        handshake("hold");

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(100 + i); select = 1'b1;
            step();
        end
        in_valid = 1'b1; in_data = 8'd200; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        send(vecs[2], 0);
        check_out("midrst_frame", vecs[2]);
        handshake("midrst");
        for (int c = 0; c < 12; c++) begin
            if (out_valid) pulses++;
            step();
        end
        chk("midrst_extra_outputs", 32'(pulses), 32'd0);

        send(vecs[7], 0);
        out_ready = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        chk("holdrst_valid", 32'(out_valid), 32'd0);
        chk("holdrst_result", 32'(result), 32'd0);

        for (int f = 0; f < 200; f++) begin
            v.sel = 1'($urandom);
            v.tog = 1'($urandom);
            for (int i = 0; i < 8; i++) v.d[i] = 8'($urandom_range(15, 0)) << (f % 5);
            r = v.d[0]; ix = '0;
            for (int i = 1; i < 8; i++)
                if (v.sel ? (v.d[i] < r) : (v.d[i] > r)) begin
                    r = v.d[i];
                    ix = 8'(i);
                end
            v.res = r; v.idx = ix;
            send(v, 2);
            check_out($sformatf("rnd%0d", f), v);
            repeat ($urandom_range(2, 0)) step();
            handshake($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
